// File: rtl/axi_module_pack.sv
// Valid/ready stream width upsizer: packs RATIO narrow beats (lane 0 first) into one
// registered wide word, with flush support that emits a partial word under a keep mask.
module axi_module_pack #(
  parameter int DWIDTH = 8,
  parameter int RATIO  = 4
) (
  input  logic                     aclk_i,
  input  logic                     aresetn_i,
  input  logic                     valid_i,
  output logic                     ready_o,
  input  logic [DWIDTH-1:0]        data_i,
  input  logic                     flush_i,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [DWIDTH*RATIO-1:0]  data_o,
  output logic [RATIO-1:0]         keep_o
);

  localparam int CW = (RATIO > 2) ? $clog2(RATIO) : 1;
  localparam int NW = $clog2(RATIO + 1);

  logic [CW-1:0]            r_cnt;
  logic                     r_flush_pend;
  logic [DWIDTH*RATIO-1:0]  r_acc;
  logic                     r_valid;
  logic [DWIDTH*RATIO-1:0]  r_data;
  logic [RATIO-1:0]         r_keep;

  logic                     w_last;
  logic                     w_ready;
  logic                     w_accept;
  logic                     w_out_free;
  logic                     w_freq;
  logic [NW-1:0]            w_n;
  logic                     w_full;
  logic                     w_flush_go;
  logic                     w_load;
  logic [DWIDTH*RATIO-1:0]  w_merged;
  logic [DWIDTH*RATIO-1:0]  w_word;
  logic [RATIO-1:0]         w_mask;

  assign w_last     = (r_cnt == CW'(RATIO - 1));
  // Refuse the closing beat while the previous word is still stalled, and hold off
  // new beats while a flush waits for the output register.
  assign w_ready    = ~r_flush_pend & ~(w_last & r_valid & ~ready_i);
  assign w_accept   = valid_i & w_ready;
  assign w_out_free = ~r_valid | ready_i;
  assign w_freq     = flush_i | r_flush_pend;
  assign w_n        = NW'(r_cnt) + NW'(w_accept);
  assign w_full     = w_accept & w_last;
  assign w_flush_go = w_freq & (w_n != '0) & w_out_free;
  assign w_load     = w_full | w_flush_go;

  genvar gi;
  generate
    for (gi = 0; gi < RATIO; gi++) begin : g_lane
      assign w_merged[gi*DWIDTH +: DWIDTH] =
        (w_accept && (r_cnt == CW'(gi))) ? data_i : r_acc[gi*DWIDTH +: DWIDTH];
      assign w_mask[gi] = (NW'(gi) < w_n);
      assign w_word[gi*DWIDTH +: DWIDTH] =
        w_mask[gi] ? w_merged[gi*DWIDTH +: DWIDTH] : '0;
    end
  endgenerate

  always_ff @(posedge aclk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      r_cnt        <= '0;
      r_flush_pend <= 1'b0;
      r_acc        <= '0;
    end else begin
      r_acc        <= w_load ? '0 : w_merged;
      r_flush_pend <= w_freq & ~w_load & (w_n != '0);
      if (w_load)
        r_cnt <= '0;
      else if (w_accept)
        r_cnt <= r_cnt + CW'(1);
    end
  end

  // A load in the same cycle as a downstream transfer simply replaces the word.
  always_ff @(posedge aclk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_keep  <= '0;
    end else if (w_load) begin
      r_valid <= 1'b1;
      r_data  <= w_word;
      r_keep  <= w_mask;
    end else if (ready_i) begin
      r_valid <= 1'b0;
    end
  end

  assign ready_o = w_ready;
  assign valid_o = r_valid;
  assign data_o  = r_data;
  assign keep_o  = r_keep;

endmodule
